// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: digit codes, active-low
// segment glyphs ({g,f,e,d,c,b,a}) and the slot-index type.
package seg_pkg;

    localparam logic [3:0] CODE_MINUS = 4'd10;
    localparam logic [3:0] CODE_R     = 4'd11;
    localparam logic [3:0] CODE_R2    = 4'd12;
    localparam logic [3:0] CODE_E     = 4'd13;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    // Active-low: a 0 bit lights the segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef logic [1:0] slot_idx_t;

    localparam slot_idx_t SLOT_LAST = 2'd3;

    // Active-low one-hot anode pattern for a slot.
    function automatic logic [3:0] anode_for(input slot_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational digit-code to active-low seven-segment pattern decoder.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (code)
            4'd0:       pattern = SEG_0;
            4'd1:       pattern = SEG_1;
            4'd2:       pattern = SEG_2;
            4'd3:       pattern = SEG_3;
            4'd4:       pattern = SEG_4;
            4'd5:       pattern = SEG_5;
            4'd6:       pattern = SEG_6;
            4'd7:       pattern = SEG_7;
            4'd8:       pattern = SEG_8;
            4'd9:       pattern = SEG_9;
            CODE_MINUS: pattern = SEG_MINUS;
            CODE_R:     pattern = SEG_R;
            CODE_R2:    pattern = SEG_R;
            CODE_E:     pattern = SEG_E;
            default:    pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with per-frame snapshot and
// per-slot anti-ghost blanking. Optional leading-zero blanking: SEG_LZ_BLANK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic       mode_ind,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);

    logic [PW-1:0]        presc;
    slot_idx_t            slot;
    logic [3:0][3:0]      snap_code;
    logic                 snap_mode;
    logic [3:0][3:0]      cap_code;
    logic                 tick;
    logic                 frame_wrap;
    logic [3:0]           sel_code;
    logic [6:0]           dec_seg;

    assign tick       = (presc == PRESC_LAST);
    assign frame_wrap = tick && (slot == SLOT_LAST);

    // Codes as they will be stored at the next frame boundary.
    always_comb begin
        cap_code = {digit3, digit2, digit1, digit0};
`ifdef SEG_LZ_BLANK_EN
        if (digit3 == 4'd0) begin
            cap_code[3] = CODE_BLANK;
            if (digit2 == 4'd0) begin
                cap_code[2] = CODE_BLANK;
                if (digit1 == 4'd0)
                    cap_code[1] = CODE_BLANK;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            slot  <= '0;
        end else if (tick) begin
            presc <= '0;
            slot  <= slot + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // The display only ever reads the snapshot, so a frame never mixes old and new digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_code <= {4{CODE_BLANK}};
            snap_mode <= 1'b0;
        end else if (frame_wrap) begin
            snap_code <= cap_code;
            snap_mode <= mode_ind;
        end
    end

    assign sel_code = snap_code[slot];

    seg_decoder u_decoder (
        .code    (sel_code),
        .pattern (dec_seg)
    );

    // Registered outputs: anodes follow the registered slot, so only one is ever low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (presc < BLANK_END) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= anode_for(slot);
            seg <= dec_seg;
            dp  <= ~((slot == SLOT_LAST) && snap_mode);
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver against a time-based reference model.
module tb_seg_scan_driver;

    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * RD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] digit [4];
    logic       mode_ind;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int errors = 0;
    int checks = 0;
    int edges  = 0;

    logic [3:0] ref_code [4];
    logic       ref_mode;
    logic [6:0] glyph [16];

    always #5 clk = ~clk;

    seg_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .digit0   (digit[0]),
        .digit1   (digit[1]),
        .digit2   (digit[2]),
        .digit3   (digit[3]),
        .mode_ind (mode_ind),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, edges, $time);
        end
    endtask

    task automatic check_blank(input string tag);
        check_val({tag, "_an"}, 32'(an), 32'hF);
        check_val({tag, "_seg"}, 32'(seg), 32'h7F);
        check_val({tag, "_dp"}, 32'(dp), 32'h1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) ref_code[i] = 4'd15;
        ref_mode = 1'b0;
        edges    = 0;
    endtask

    // Frame-boundary capture, with leading zeros suppressed when the option is built in.
    task automatic capture();
`ifdef SEG_LZ_BLANK_EN
        bit lead = 1'b1;
`endif
        for (int i = 3; i >= 0; i--) begin
            ref_code[i] = digit[i];
`ifdef SEG_LZ_BLANK_EN
            if (lead && i > 0 && digit[i] == 4'd0) ref_code[i] = 4'd15;
            else lead = 1'b0;
`endif
        end
        ref_mode = mode_ind;
    endtask

    // Outputs seen after edge k show the scan position reached after k-1 edges.
    task automatic check_outputs();
        int s, pos, slot;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        s    = edges - 1;
        pos  = s % RD;
        slot = (s / RD) % 4;
        if (pos < BC) begin
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
        end else begin
            exp_an  = 4'hF & ~(4'h1 << slot);
            exp_seg = glyph[ref_code[slot]];
            exp_dp  = !(slot == 3 && ref_mode);
        end
        check_val("an", 32'(an), 32'(exp_an));
        check_val("seg", 32'(seg), 32'(exp_seg));
        check_val("dp", 32'(dp), 32'(exp_dp));
        check_val("one_slot", 32'($countones(~an) <= 1), 32'h1);
    endtask

    task automatic step();
        @(posedge clk);
        edges++;
        #1;
        check_outputs();
        if (edges % FRAME == 0) capture();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        digit[3] = d3;
        digit[2] = d2;
        digit[1] = d1;
        digit[0] = d0;
    endtask

    initial begin
        glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100;
        glyph[3]  = 7'b0110000; glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010;
        glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000; glyph[8]  = 7'b0000000;
        glyph[9]  = 7'b0010000; glyph[10] = 7'b0111111; glyph[11] = 7'b0101111;
        glyph[12] = 7'b0101111; glyph[13] = 7'b0000110; glyph[14] = 7'b1111111;
        glyph[15] = 7'b1111111;

        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        mode_ind = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_blank("rst_assert");
        @(posedge clk);
        @(posedge clk);
        #1 check_blank("rst_hold");
        rst_n = 1'b1;
        model_reset();

        // First frame after release stays blank, then shows 4,3,2,1 in slots 0..3.
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        run(2 * FRAME);

        // Mid-frame input change is invisible until the next frame boundary.
        run(RD + 3);
        digit[0] = 4'd7;
        run(2 * FRAME);

        set_digits(4'd13, 4'd12, 4'd11, 4'd11);
        run(2 * FRAME);
        set_digits(4'd0, 4'd10, 4'd4, 4'd2);
        mode_ind = 1'b1;
        run(2 * FRAME);
        mode_ind = 1'b0;
        run(2 * FRAME);

        set_digits(4'd0, 4'd0, 4'd0, 4'd5);
        run(2 * FRAME);
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        run(2 * FRAME);
        set_digits(4'd0, 4'd3, 4'd0, 4'd0);
        run(2 * FRAME);

        repeat (40) begin
            set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            mode_ind = 1'($urandom_range(0, 1));
            run($urandom_range(1, 40));
        end

        // Reset in the lit part of a slot blanks immediately and drops the snapshot.
        for (int i = 0; i < RD; i++) begin
            if (edges % RD == 4) break;
            step();
        end
        #2 rst_n = 1'b0;
        #1 check_blank("rst_midslot");
        @(posedge clk);
        #1 check_blank("rst_midslot_hold");
        rst_n = 1'b1;
        model_reset();
        set_digits(4'd9, 4'd8, 4'd7, 4'd6);
        mode_ind = 1'b1;
        run(2 * FRAME + 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
